// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types, constants and helpers for the shift-add multiplier
//
// Purpose: state encoding, default operand width and a constant-evaluable
//          clog2 used to size the iteration counter.
// Ports:   none (package).
package mult_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2, never below 1 so it can size a vector directly.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/ripple_adder.sv
// rtl/ripple_adder.sv - WIDTH-bit ripple-carry adder
//
// Purpose: combinational unsigned adder built from a chain of full adders.
// Ports:
//   a, b  WIDTH-bit addends
//   cin   carry in
//   sum   WIDTH-bit sum
//   cout  carry out of the most significant bit
module ripple_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned shift-and-add multiplier
//
// Purpose: WIDTH x WIDTH unsigned multiply, one partial-product step per
//          clock, with a start/done handshake and a held product register.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    request, sampled only while idle
//   a, b     multiplicand / multiplier, captured on the accepting edge
//   busy     high while an operation is in flight (CALC or DONE)
//   done     one-cycle pulse, product valid
//   product  2*WIDTH-bit result, held until the next operation completes
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [2*WIDTH-1:0] acc_shifted;
  logic               last_iter;

  // The low multiplier bit selects whether this step adds the multiplicand.
  assign addend = lo[0] ? mcand : '0;

  ripple_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a    (hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // {cout, sum, lo} shifted right by one: the carry becomes the new top bit,
  // so it is never lost, and sum[0] moves into the low half.
  assign acc_shifted = {cout, sum, lo[WIDTH-1:1]};
  assign last_iter   = (cnt == LAST_ITER);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            hi    <= '0;
            lo    <= b;
            cnt   <= '0;
          end
        end
        CALC: begin
          {hi, lo} <= acc_shifted;
          cnt      <= cnt + CW'(1);
          if (last_iter) begin
            product <= acc_shifted;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
